step_sequencer: RTL
===================

// Module: step_sequencer
// PURPOSE
//  Controller stage directly upstream of the 2 s interval timer: drives the timer's enable and consumes its done pulse.
//  Runs a start-triggered sequence of NUM_STEPS equal-length steps, one timer period each, and exposes the active step.
//  Re-arms the timer between steps by dropping enable for exactly one cycle, which clears the timer's counter.
//  Outputs feed the display/LED logic; start/abort come from the synchronised, debounced button logic.
// PARAMETERS
//  NUM_STEPS  4                        number of timed steps per sequence (>=2)
//  STEP_W     $clog2(NUM_STEPS)        width of step_idx (derived localparam, not overridable)
// PORTS
//  clock         in   1        system clock, 100 MHz, all logic on posedge
//  reset         in   1        asynchronous, active-high reset
//  start         in   1        1-cycle pulse: begin a sequence (ignored unless IDLE)
//  abort         in   1        level: terminate sequence, return to IDLE
//  done_signal   in   1        timer expiry; 1-cycle high pulse while timer enabled
//  enable        out  1        timer enable; high only in RUN
//  step_idx      out  STEP_W   current step, 0..NUM_STEPS-1
//  step_onehot   out  NUM_STEPS  one-hot of step_idx while busy, all-zero otherwise
//  busy          out  1        high in ARM and RUN
//  finished      out  1        1-cycle pulse after last step completes
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, step_idx=0, all outputs 0, done_q=0.
//  All outputs are Moore-decoded from registered state/step; no combinational input->output path.
//  done_rise = done_signal & ~done_q; done_q is done_signal registered every cycle in every state.
//  States:
//   IDLE : start -> ARM, step_idx<=0. Else stay.
//   ARM  : enable=0 for exactly one cycle -> RUN. done_rise ignored here.
//   RUN  : enable=1. On done_rise: step_idx<NUM_STEPS-1 -> step_idx+1, ARM;
//          step_idx==NUM_STEPS-1 -> FIN (or wrap, see CONFIGURATION).
//   FIN  : finished=1 for one cycle -> IDLE, step_idx<=0.
//  Latency: start at cycle n -> busy=1 at n+1, enable=1 at n+2. done_rise at m -> enable=0 at m+1, enable=1 at m+2.
//  abort in ARM/RUN/FIN -> IDLE next cycle, step_idx<=0, finished not pulsed. abort in IDLE no effect.
//  abort and done_rise in same cycle: abort wins. abort and start in IDLE in same cycle: stay IDLE.
//  start while busy or in FIN: ignored, not queued.
//  step_idx never exceeds NUM_STEPS-1; increment is STEP_W-bit, compared before increment (no wrap-through).
//  Reset mid-sequence: immediate IDLE, enable drops asynchronously, no finished pulse.
// CONFIGURATION
//  STEP_SEQ_LOOP_EN defined: in RUN at last step, done_rise -> step_idx<=0, ARM (continuous loop);
//   FIN never entered, finished pulses for one cycle on each wrap, busy stays 1; only abort/reset exits.
//  Not defined: single-shot behaviour as above.
// STRUCTURE
//  Package step_seq_pkg: typedef enum logic [1:0] {IDLE, ARM, RUN, FIN} seq_state_t; state encodings only.
//  Sub-module rise_detect (1-bit registered edge detector, clock/reset, in -> pulse) produces done_rise.
//  FSM, step counter, output decode in this module; timer instantiated by the parent, not here.
// TESTING (bench models the timer: done_signal pulses 1 cycle, 10 cycles after enable rises, cleared while enable=0)
//  1 NUM_STEPS=4, start pulse -> step_idx 0,1,2,3, enable low 1 cycle between steps, finished pulse once, busy=0 after.
//  2 abort in RUN at step 2 -> IDLE next cycle, enable=0, step_idx=0, no finished pulse.
//  3 abort coincident with done_rise at step 3 -> IDLE, finished stays 0.
//  4 start pulses during RUN and FIN -> ignored; sequence timing identical to test 1.
//  5 reset asserted mid-step 1 (between clock edges) -> enable, busy, step_onehot 0 immediately; new start runs fully.
//  6 STEP_SEQ_LOOP_EN, 9 done pulses -> step_idx 0,1,2,3,0,1,2,3,0,1; finished pulses twice; busy never drops.

Source files
------------

// File: rtl/step_seq_pkg.sv
// Shared state encoding for the step sequencer.
package step_seq_pkg;

    typedef enum logic [1:0] {IDLE, ARM, RUN, FIN} seq_state_t;

endpackage

// File: rtl/step_sequencer_rise_detect.sv
// Registered rising-edge detector: pulse is high for the first cycle level is seen high.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) level_q <= 1'b0;
        else       level_q <= level;
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/step_sequencer.sv
// Timed step sequencer driving an interval timer's enable and consuming its done pulse.
// Define STEP_SEQ_LOOP_EN for continuous looping (finished pulses on each wrap).
module step_sequencer
    import step_seq_pkg::*;
#(
    parameter  int unsigned NUM_STEPS = 4,
    localparam int unsigned STEP_W    = $clog2(NUM_STEPS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 done_signal,
    output logic                 enable,
    output logic [STEP_W-1:0]    step_idx,
    output logic [NUM_STEPS-1:0] step_onehot,
    output logic                 busy,
    output logic                 finished
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    seq_state_t        state, state_next;
    logic [STEP_W-1:0] step_q, step_next;
    logic              done_rise;
`ifdef STEP_SEQ_LOOP_EN
    logic              wrap_q, wrap_next;
`endif

    rise_detect u_done_rise (
        .clock (clock),
        .reset (reset),
        .level (done_signal),
        .pulse (done_rise)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            step_q <= '0;
        end else begin
            state  <= state_next;
            step_q <= step_next;
        end
    end

`ifdef STEP_SEQ_LOOP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) wrap_q <= 1'b0;
        else       wrap_q <= wrap_next;
    end
`endif

    always_comb begin
        state_next = state;
        step_next  = step_q;
`ifdef STEP_SEQ_LOOP_EN
        wrap_next  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = ARM;
                    step_next  = '0;
                end
            end
            ARM: state_next = RUN;
            RUN: begin
                if (done_rise) begin
                    // Compare before incrementing so the index never passes LAST_STEP.
                    if (step_q != LAST_STEP) begin
                        step_next  = step_q + 1'b1;
                        state_next = ARM;
                    end else begin
`ifdef STEP_SEQ_LOOP_EN
                        step_next  = '0;
                        state_next = ARM;
                        wrap_next  = 1'b1;
`else
                        state_next = FIN;
`endif
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
                step_next  = '0;
            end
            default: begin
                state_next = IDLE;
                step_next  = '0;
            end
        endcase

        // Abort overrides any transition taken above, including a coincident done.
        if (abort && state != IDLE) begin
            state_next = IDLE;
            step_next  = '0;
`ifdef STEP_SEQ_LOOP_EN
            wrap_next  = 1'b0;
`endif
        end
    end

    assign enable      = (state == RUN);
    assign busy        = (state == ARM) || (state == RUN);
    assign step_idx    = step_q;
    assign step_onehot = busy ? (NUM_STEPS'(1) << step_q) : '0;
`ifdef STEP_SEQ_LOOP_EN
    assign finished    = wrap_q;
`else
    assign finished    = (state == FIN);
`endif

endmodule
